// File: rtl/comm_uart_fifo.sv
// Full-duplex UART with TX and RX FIFOs and valid/ready host handshakes.
// Frame: start, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
module comm_uart_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              UART_RX,
    output logic              UART_TX,
    output logic              busy_uart,
    output logic              new_uart,
    output logic              err_parity,
    output logic              err_frame,
    output logic              rx_overrun
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} uart_state_t;

    // TX FIFO: one extra pointer bit separates full from empty
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wr, tx_rd;
    logic              tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
    end

    uart_state_t       tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d, tx_head;
    logic              tx_par_q, tx_par_d, tx_line_q, tx_line_d, tx_load;

    assign tx_head = tx_mem[tx_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // The line value is computed one cycle ahead so UART_TX comes straight from a flop
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                tx_load   = !tx_empty;
            end
            S_START: if (tx_cnt_q == CNT_LAST) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_line_d  = tx_shift_q[0];
            end
            S_DATA: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == BIT_LAST) begin
                    tx_bit_d = '0;
                    if (PARITY != 0) begin
                        tx_state_d = S_PAR;
                        tx_line_d  = tx_par_q;
                    end else begin
                        tx_state_d = S_STOP;
                        tx_line_d  = 1'b1;
                    end
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_line_d  = tx_shift_q[1];
                end
            end
            S_PAR: if (tx_cnt_q == CNT_LAST) begin
                tx_state_d = S_STOP;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_line_d  = 1'b1;
            end
            S_STOP: if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == STOP_LAST) begin
                    tx_state_d = S_IDLE;
                    tx_line_d  = 1'b1;
                    tx_load    = !tx_empty;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_head;
            tx_par_d   = (^tx_head) ^ PAR_ODD;
            tx_line_d  = 1'b0;
        end
    end

    assign UART_TX   = tx_line_q;
    assign busy_uart = (tx_state_q != S_IDLE) || !tx_empty;

    // RX synchroniser; the third flop only feeds the falling-edge detect
    logic rx_s1, rx_s2, rx_s3, rx_fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= UART_RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 && !rx_s2;

    uart_state_t       rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_par_q, rx_par_d, frame_end;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
        end
    end

    // Only the first stop bit is sampled; returning to IDLE there allows early resync
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        frame_end  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2, rx_shift_q[DATA_W-1:1]};
                if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
                else                      rx_bit_d   = rx_bit_q + 1'b1;
            end
            S_PAR: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_par_d   = rx_s2;
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = S_IDLE;
                frame_end  = 1'b1;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX FIFO and frame-end resolution
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       rx_wr, rx_rd;
    logic              rx_empty, rx_full, rx_pop, rx_push;
    logic              par_bad, stop_bad, frame_good, overrun_d;

    assign rx_empty   = (rx_wr == rx_rd);
    assign rx_full    = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign rx_valid   = !rx_empty;
    assign rx_data    = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
    assign rx_pop     = rx_valid && rx_ready;
    assign par_bad    = (PARITY != 0) && (((^rx_shift_q) ^ rx_par_q) != PAR_ODD);
    assign stop_bad   = !rx_s2;
    assign frame_good = frame_end && !par_bad && !stop_bad;
    assign rx_push    = frame_good && (!rx_full || rx_pop);
    assign overrun_d  = frame_good && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_wr      <= '0;
            rx_rd      <= '0;
            new_uart   <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            new_uart   <= rx_push;
            err_parity <= frame_end && par_bad;
            err_frame  <= frame_end && !par_bad && stop_bad;
            rx_overrun <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift_q;
    end

endmodule

// File: tb/tb_comm_uart_fifo.sv
// Self-checking bench for comm_uart_fifo (8 data bits, even parity, 1 stop, 4 clocks/bit).
// Uses table-driven RX frames, randomized loopback traffic and hand-written reset/full sequences.
module tb_comm_uart_fifo;

    localparam int CPB   = 4;
    localparam int FRAME = 11 * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       uart_rx, uart_tx;
    logic       busy_uart, new_uart, err_parity, err_frame, rx_overrun;
    logic       loopback = 1'b0;
    logic       rx_drive = 1'b1;

    int errors = 0;
    int checks = 0;
    int n_new = 0, n_perr = 0, n_ferr = 0, n_ovr = 0;

    logic [7:0] tx_words [4];
    logic [7:0] model_q [$];

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         glitch;
        int         exp_new;
        int         exp_perr;
        int         exp_ferr;
        int         exp_ovr;
    } rx_vec_t;

    rx_vec_t vecs [9];

    always #5 clk = ~clk;

    assign uart_rx = loopback ? uart_tx : rx_drive;

    comm_uart_fifo #(
        .DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .UART_RX(uart_rx), .UART_TX(uart_tx), .busy_uart(busy_uart),
        .new_uart(new_uart), .err_parity(err_parity), .err_frame(err_frame),
        .rx_overrun(rx_overrun)
    );

    // Pulse counters: tests compare the change across a frame
    always @(negedge clk) begin
        if (new_uart)   n_new++;
        if (err_parity) n_perr++;
        if (err_frame)  n_ferr++;
        if (rx_overrun) n_ovr++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame bit b of a word: start, data LSB first, even parity, stop
    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9) return ^d;
        return 1'b1;
    endfunction

    // Push n words back to back and check the serial line and busy flag cycle by cycle
    task automatic apply_stimulus(input int n);
        int total, i;
        total = n * FRAME;
        @(negedge clk);
        for (int t = 0; t <= total + 2; t++) begin
            if (t < n) begin
                check_output("tx_ready_push", tx_ready, 1);
                tx_valid = 1'b1;
                tx_data  = tx_words[t];
            end else begin
                tx_valid = 1'b0;
            end
            if (t >= 2) begin
                i = t - 2;
                check_output("uart_tx_bit", uart_tx, (i < total) ? frame_bit(tx_words[i / FRAME], (i % FRAME) / CPB) : 1'b1);
                check_output("busy_uart", busy_uart, i < total);
            end
            @(negedge clk);
        end
    endtask

    task automatic drive_rx_frame(input rx_vec_t v);
        logic [10:0] bits;
        if (v.glitch) begin
            rx_drive = 1'b0;
            @(negedge clk);
            rx_drive = 1'b1;
            repeat (12) @(negedge clk);
        end else begin
            for (int b = 0; b < 11; b++) bits[b] = frame_bit(v.data, b);
            bits[9]  = bits[9] ^ v.bad_par;
            bits[10] = !v.bad_stop;
            for (int b = 0; b < 11; b++) begin
                rx_drive = bits[b];
                repeat (CPB) @(negedge clk);
            end
            rx_drive = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic drain_rx();
        while (model_q.size() > 0) begin
            check_output("rx_valid_drain", rx_valid, 1);
            check_output("rx_data_drain", rx_data, model_q[0]);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            void'(model_q.pop_front());
        end
        check_output("rx_valid_empty", rx_valid, 0);
    endtask

    initial begin
        int b_new, b_perr, b_ferr, b_ovr, n, busy_cnt, t;

        vecs[0] = '{8'h55, 1, 0, 0, 0, 1, 0, 0};
        vecs[1] = '{8'h55, 0, 1, 0, 0, 0, 1, 0};
        vecs[2] = '{8'h00, 0, 0, 1, 0, 0, 0, 0};
        vecs[3] = '{8'h01, 0, 0, 0, 1, 0, 0, 0};
        vecs[4] = '{8'h02, 0, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{8'h03, 0, 0, 0, 1, 0, 0, 0};
        vecs[6] = '{8'h04, 0, 0, 0, 1, 0, 0, 0};
        vecs[7] = '{8'h05, 0, 0, 0, 0, 0, 0, 1};
        vecs[8] = '{8'hFF, 1, 1, 0, 0, 1, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_output("rst_uart_tx", uart_tx, 1);
        check_output("rst_tx_ready", tx_ready, 1);
        check_output("rst_rx_valid", rx_valid, 0);
        check_output("rst_rx_data", rx_data, 0);
        check_output("rst_busy", busy_uart, 0);
        check_output("rst_pulses", {new_uart, err_parity, err_frame, rx_overrun}, 0);

        // Single 0xA5 frame on the TX line
        tx_words[0] = 8'hA5;
        apply_stimulus(1);

        // Table-driven RX frames with rx_ready held low (last vector hits a full FIFO but fails parity first)
        for (int k = 0; k < 9; k++) begin
            b_new = n_new; b_perr = n_perr; b_ferr = n_ferr; b_ovr = n_ovr;
            drive_rx_frame(vecs[k]);
            if (!vecs[k].glitch && !vecs[k].bad_par && !vecs[k].bad_stop && model_q.size() < 4)
                model_q.push_back(vecs[k].data);
            check_output("rx_new_uart", n_new - b_new, vecs[k].exp_new);
            check_output("rx_err_parity", n_perr - b_perr, vecs[k].exp_perr);
            check_output("rx_err_frame", n_ferr - b_ferr, vecs[k].exp_ferr);
            check_output("rx_overrun", n_ovr - b_ovr, vecs[k].exp_ovr);
            check_output("rx_valid", rx_valid, model_q.size() != 0);
            if (model_q.size() != 0) check_output("rx_head", rx_data, model_q[0]);
        end
        drain_rx();

        // Loopback: fixed 0x3C/0xC3 pair, then randomized bursts
        loopback = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r == 0) begin
                n = 2;
                tx_words[0] = 8'h3C;
                tx_words[1] = 8'hC3;
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < 4; k++) tx_words[k] = 8'($urandom);
            end
            b_new = n_new; b_perr = n_perr; b_ferr = n_ferr; b_ovr = n_ovr;
            apply_stimulus(n);
            repeat (10) @(negedge clk);
            for (int k = 0; k < n; k++) model_q.push_back(tx_words[k]);
            check_output("lb_new_uart", n_new - b_new, n);
            check_output("lb_errors", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
            drain_rx();
        end
        loopback = 1'b0;

        // Reset during data bit 3 of the first word with three words still queued
        tx_words[0] = 8'hF7; tx_words[1] = 8'h11; tx_words[2] = 8'h22; tx_words[3] = 8'h33;
        @(negedge clk);
        for (t = 0; t < 20; t++) begin
            tx_valid = (t < 4);
            if (t < 4) tx_data = tx_words[t];
            if (t == 18) begin
                check_output("pre_rst_bit3", uart_tx, 0);
                check_output("pre_rst_busy", busy_uart, 1);
                reset_n = 1'b0;
            end
            if (t == 19) begin
                reset_n = 1'b1;
                check_output("mid_rst_uart_tx", uart_tx, 1);
                check_output("mid_rst_busy", busy_uart, 0);
                check_output("mid_rst_tx_ready", tx_ready, 1);
                check_output("mid_rst_rx_valid", rx_valid, 0);
            end
            @(negedge clk);
        end
        repeat (60) @(negedge clk);
        check_output("post_rst_idle", {uart_tx, busy_uart}, 2'b10);

        // Six pushes in a row: the sixth meets a full FIFO and is ignored
        busy_cnt = 0;
        t = 0;
        while (t < 600 && !(t >= 2 && !busy_uart)) begin
            tx_valid = (t < 6);
            tx_data  = 8'(t + 1);
            if (t >= 1 && t <= 4) check_output("fill_tx_ready", tx_ready, 1);
            if (t == 5) check_output("full_tx_ready", tx_ready, 0);
            if (t >= 1 && busy_uart) busy_cnt++;
            @(negedge clk);
            t++;
        end
        tx_valid = 1'b0;
        check_output("full_busy_cycles", busy_cnt, 1 + 5 * FRAME);
        check_output("full_drained_ready", tx_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
